// File: rtl/instruction_loader.sv
// Debug-UART program loader: assembles bytes into instruction words,
// writes them to instruction memory and gates the fetch halt line.
module instruction_loader #(
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_WORDS  = 64
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_valid,
   output logic                  o_rx_ready,
   input  logic                  i_program_end,
   output logic                  o_halt,
   output logic                  o_write_instruction,
   output logic [31:0]           o_instruction,
   output logic [ADDR_WIDTH-1:0] o_address,
   output logic                  o_busy,
   output logic                  o_error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RX_COUNT,
      S_RX_WORD,
      S_WRITE,
      S_RUN,
      S_STEP
   } state_t;

   localparam logic [7:0] C_LOAD = 8'h01;
   localparam logic [7:0] C_RUN  = 8'h02;
   localparam logic [7:0] C_STEP = 8'h03;
   localparam logic [7:0] C_STOP = 8'h04;
   // Word counts travel as one byte, so the limit is held in 8 bits.
   localparam logic [7:0] C_MAXN = 8'(MAX_WORDS);

   state_t                r_state;
   state_t                w_next;
   logic [31:0]           r_instr;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_count;
   logic [7:0]            r_words;
   logic [1:0]            r_bytes;
   logic                  r_error;
   logic                  w_error;
   logic                  w_accept;
   logic [7:0]            w_words_inc;

   assign o_rx_ready = (r_state == S_IDLE)     ||
                       (r_state == S_RX_COUNT) ||
                       (r_state == S_RX_WORD)  ||
                       (r_state == S_RUN);
   assign w_accept      = i_rx_valid && o_rx_ready;
   assign w_words_inc   = r_words + 8'd1;
   assign o_instruction = r_instr;
   assign o_address     = r_addr;
   assign o_error       = r_error;
   assign o_busy        = (r_state != S_IDLE);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next              = r_state;
      w_error             = 1'b0;
      o_halt              = 1'b1;
      o_write_instruction = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (i_rx_data == C_LOAD) begin
                  w_next = S_RX_COUNT;
               end else if (i_rx_data == C_RUN) begin
                  w_next = S_RUN;
               end else if (i_rx_data == C_STEP) begin
                  w_next = S_STEP;
               end else begin
                  w_error = 1'b1;
               end
            end
         end
         S_RX_COUNT: begin
            if (w_accept) begin
               if (i_rx_data == 8'd0 || i_rx_data > C_MAXN) begin
                  w_error = 1'b1;
                  w_next  = S_IDLE;
               end else begin
                  w_next = S_RX_WORD;
               end
            end
         end
         S_RX_WORD: begin
            if (w_accept && r_bytes == 2'd3) begin
               w_next = S_WRITE;
            end
         end
         S_WRITE: begin
            o_write_instruction = 1'b1;
            w_next = (w_words_inc == r_count) ? S_IDLE : S_RX_WORD;
         end
         S_RUN: begin
            o_halt = 1'b0;
            if (w_accept && i_rx_data != C_STOP) begin
               w_error = 1'b1;
            end
            // Program end wins; a STOP on the same edge is then harmless.
            if (i_program_end || (w_accept && i_rx_data == C_STOP)) begin
               w_next = S_IDLE;
            end
         end
         S_STEP: begin
            o_halt = 1'b0;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_instr <= '0;
         r_addr  <= '0;
         r_count <= '0;
         r_words <= '0;
         r_bytes <= '0;
         r_error <= 1'b0;
      end else begin
         r_error <= w_error;
         if (r_state == S_RX_COUNT && w_accept && w_next == S_RX_WORD) begin
            r_count <= i_rx_data;
            r_addr  <= '0;
            r_words <= '0;
            r_bytes <= '0;
         end
         if (r_state == S_RX_WORD && w_accept) begin
            r_instr <= {r_instr[23:0], i_rx_data};
            r_bytes <= r_bytes + 2'd1;
         end
         if (r_state == S_WRITE) begin
            r_addr  <= r_addr + ADDR_WIDTH'(4);
            r_words <= w_words_inc;
         end
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: randomized loads, command
// errors, run/stop, step and asynchronous reset against a fetch PC model.
module tb_instruction_loader;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        program_end = 1'b0;
   logic        halt;
   logic        wr;
   logic [31:0] instr;
   logic [31:0] addr;
   logic        busy;
   logic        err;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          exp_err = 0;
   int          obs_err = 0;
   bit          loading = 1'b0;
   logic [31:0] pc = 32'h0;
   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [31:0] words[$];

   instruction_loader #(.ADDR_WIDTH(32), .MAX_WORDS(64)) dut (
      .i_clk               (clk),
      .i_reset             (rst_n),
      .i_rx_data           (rx_data),
      .i_rx_valid          (rx_valid),
      .o_rx_ready          (rx_ready),
      .i_program_end       (program_end),
      .o_halt              (halt),
      .o_write_instruction (wr),
      .o_instruction       (instr),
      .o_address           (addr),
      .o_busy              (busy),
      .o_error             (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Fetch stage stand-in: PC moves one instruction per unhalted cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc <= 32'h0;
      else if (!halt) pc <= pc + 32'd4;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         if (loading) chk("halt_during_load", halt, 1);
         if (err) obs_err++;
         if (wr) begin
            chk("write_vs_error", err, 0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write addr=%h data=%h", addr, instr);
            end else begin
               mon_e = exp_q.pop_front();
               chk("wr_addr", addr, mon_e.addr);
               chk("wr_data", instr, mon_e.data);
               chk("wr_cycle", cyc, mon_e.cyc);
            end
         end
      end
   end

   task automatic send(input logic [7:0] b, input int gap, output int k);
      int n;
      repeat (gap) @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      n = 0;
      while (!rx_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) begin
         checks++;
         errors++;
         $display("FAIL rx_ready_timeout act=0 exp=1 byte=%h", b);
      end
      k = cyc;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("return_idle", busy, 0);
   endtask

   task automatic check_err();
      @(negedge clk);
      #2;
      chk("error_count", obs_err, exp_err);
   endtask

   task automatic do_load(input int gmin, input int gmax);
      int   k;
      wr_t  e;
      logic [7:0] b;
      loading = 1'b1;
      send(8'h01, $urandom_range(gmin, gmax), k);
      send(8'(words.size()), $urandom_range(gmin, gmax), k);
      for (int i = 0; i < words.size(); i++) begin
         for (int j = 3; j >= 0; j--) begin
            b = words[i][8*j +: 8];
            send(b, $urandom_range(gmin, gmax), k);
         end
         e.addr = 32'(4 * i);
         e.data = words[i];
         e.cyc  = k + 1;
         exp_q.push_back(e);
      end
      wait_idle();
      repeat (2) @(negedge clk);
      loading = 1'b0;
      chk("queue_drained", exp_q.size(), 0);
   endtask

   task automatic rand_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int run;
      logic [31:0] p;
      logic [7:0] b;

      repeat (3) @(negedge clk);
      chk("rst_halt", halt, 1);
      chk("rst_write", wr, 0);
      chk("rst_instr", instr, 0);
      chk("rst_addr", addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_error", err, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", rx_ready, 1);
      chk("idle_halt", halt, 1);

      words = {32'h10101010, 32'h12345678, 32'hABCDEF01, 32'hFEDCBA98};
      do_load(0, 0);
      chk("load_done_halt", halt, 1);

      words = {32'hDEADBEEF};
      do_load(2, 2);

      for (int it = 0; it < 5; it++) begin
         rand_words($urandom_range(1, 8));
         do_load(0, 3);
      end
      rand_words(64);
      do_load(0, 0);
      check_err();

      send(8'h7F, 1, k);
      exp_err++;
      #1 chk("bad_cmd_pulse", err, 1);
      @(negedge clk);
      #1 chk("bad_cmd_one_cycle", err, 0);
      chk("bad_cmd_idle", busy, 0);
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom_range(4, 255));
         if (i == 0) b = 8'h00;
         send(b, 1, k);
         exp_err++;
      end
      send(8'h01, 1, k);
      send(8'h00, 0, k);
      exp_err++;
      wait_idle();
      send(8'h01, 1, k);
      send(8'h41, 0, k);
      exp_err++;
      wait_idle();
      send(8'h01, 1, k);
      send(8'($urandom_range(66, 255)), 0, k);
      exp_err++;
      wait_idle();
      repeat (3) @(negedge clk);
      check_err();

      send(8'h02, 1, k);
      chk("run_halt_low", halt, 0);
      run = $urandom_range(3, 10);
      p = pc;
      repeat (run) @(negedge clk);
      chk("run_pc_advance", pc, p + 32'(4 * run));
      send(8'h55, 0, k);
      exp_err++;
      chk("run_bad_byte_stays", busy, 1);
      send(8'h04, 1, k);
      chk("stop_halt", halt, 1);
      chk("stop_idle", busy, 0);
      p = pc;
      @(negedge clk);
      chk("stop_pc_frozen", pc, p);

      send(8'h02, 1, k);
      repeat (3) @(negedge clk);
      program_end = 1'b1;
      @(negedge clk);
      program_end = 1'b0;
      chk("pend_idle", busy, 0);
      chk("pend_halt", halt, 1);

      send(8'h02, 1, k);
      repeat (2) @(negedge clk);
      program_end = 1'b1;
      send(8'h04, 0, k);
      program_end = 1'b0;
      chk("stop_pend_idle", busy, 0);
      check_err();

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("step_pc_start", pc, 0);
      for (int i = 0; i < 3; i++) begin
         send(8'h03, 1, k);
         chk("step_halt_low", halt, 0);
         @(negedge clk);
         chk("step_halt_back", halt, 1);
         chk("step_idle", busy, 0);
      end
      chk("step_pc_final", pc, 32'hC);
      check_err();

      rand_words(2);
      loading = 1'b1;
      send(8'h01, 0, k);
      send(8'h04, 0, k);
      for (int i = 0; i < 2; i++) begin
         for (int j = 3; j >= 0; j--) begin
            b = words[i][8*j +: 8];
            send(b, 0, k);
         end
         mon_e.addr = 32'(4 * i);
         mon_e.data = words[i];
         mon_e.cyc  = k + 1;
         exp_q.push_back(mon_e);
      end
      repeat (2) @(negedge clk);
      loading = 1'b0;
      chk("partial_queue", exp_q.size(), 0);
      chk("partial_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_busy", busy, 0);
      chk("async_halt", halt, 1);
      chk("async_write", wr, 0);
      chk("async_instr", instr, 0);
      chk("async_addr", addr, 0);
      chk("async_error", err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rand_words(1);
      do_load(0, 1);
      check_err();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
